// File: rtl/mealy_stream_decoder.sv
// mealy_stream_decoder
// ---------------------------------------------------------------------------
// Receive-side inverse of the three-state Mealy encoder (states A/B/C, reset
// state B). Accepts the encoder's serial Y stream on a valid/ready handshake,
// tracks the encoder state, recovers each X bit and packs the recovered bits
// LSB-first into W-bit words. Completed words are presented on a registered
// valid/ready output.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   sync           synchronous re-align: tracker to B, partial word discarded
//   y_valid, y_in  encoder Y bit stream input
//   y_ready        decoder accepts y_in this cycle (combinational)
//   word_valid     word_out holds a complete recovered word
//   word_out       recovered X bits, first-received bit in bit 0
//   word_ready     downstream takes word_out this cycle
//   tracker_state  mirrored encoder state: A=0, B=1, C=2
//   bit_count      number of bits held in the partial word
//   word_total     (only with MEALY_DEC_STATS_EN) wrapping count of words loaded
//
// Optional feature macro: MEALY_DEC_STATS_EN adds the word_total counter port.
// ---------------------------------------------------------------------------
module mealy_stream_decoder #(
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync,
    input  logic                     y_valid,
    input  logic                     y_in,
    output logic                     y_ready,
    output logic                     word_valid,
    output logic [W-1:0]             word_out,
    input  logic                     word_ready,
    output logic [1:0]               tracker_state,
    output logic [$clog2(W+1)-1:0]   bit_count
`ifdef MEALY_DEC_STATS_EN
    ,
    output logic [15:0]              word_total
`endif
);

    localparam int CW = $clog2(W+1);
    localparam logic [CW-1:0] LAST = CW'(W-1);

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    w_shift_set;
    logic [W-1:0]    r_word;
    logic [CW-1:0]   r_count;
    logic            r_valid;

    logic            w_acc;
    logic            w_x;
    logic            w_legal;
    logic            w_take;
    logic            w_last;

    // Only the word-completing bit has to wait for the output register;
    // partial bits are always taken.
    assign y_ready = !sync && (!r_valid || word_ready || (r_count != LAST));
    assign w_acc   = y_valid && y_ready;

    // Tracker: recover x from y and the mirrored encoder state, then step the
    // state with the recovered x exactly as the encoder did.
    always_comb begin
        w_state_next = r_state;
        w_x          = 1'b0;
        w_legal      = 1'b1;
        case (r_state)
            ST_A: begin
                w_x = ~y_in;
                if (w_acc) w_state_next = w_x ? ST_B : ST_A;
            end
            ST_B: begin
                w_x = ~y_in;
                if (w_acc) w_state_next = w_x ? ST_C : ST_A;
            end
            ST_C: begin
                w_x = y_in;
                if (w_acc) w_state_next = w_x ? ST_A : ST_B;
            end
            default: begin
                // Corrupted encoding: fall back to B, consume nothing.
                w_legal      = 1'b0;
                w_state_next = ST_B;
            end
        endcase
    end

    assign w_take = w_acc && w_legal;
    assign w_last = w_take && (r_count == LAST);

    // Shift register with the incoming bit placed at position bit_count.
    // When the last bit arrives this is the complete word.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_shift
            localparam logic [CW-1:0] POS = CW'(gi);
            assign w_shift_set[gi] = (w_take && (r_count == POS)) ? w_x : r_shift[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_B;
        end else if (sync) begin
            r_state <= ST_B;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Word assembly and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            // Drain first; a load in the same cycle overrides it below.
            if (r_valid && word_ready) begin
                r_valid <= 1'b0;
            end
            if (sync) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_last) begin
                r_word  <= w_shift_set;
                r_valid <= 1'b1;
                r_shift <= '0;
                r_count <= '0;
            end else if (w_take) begin
                r_shift <= w_shift_set;
                r_count <= r_count + CW'(1);
            end
        end
    end

`ifdef MEALY_DEC_STATS_EN
    logic [15:0] r_total;

    // Counts word loads; survives sync, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total <= '0;
        end else if (!sync && w_last) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign word_total = r_total;
`endif

    assign word_valid    = r_valid;
    assign word_out      = r_word;
    assign tracker_state = r_state;
    assign bit_count     = r_count;

endmodule

// File: tb/tb_mealy_stream_decoder.sv
// Testbench for mealy_stream_decoder (W = 8).
// Words are checked through a scoreboard queue: the expected word is pushed
// when its last bit is driven and popped when the DUT hands the word over.
module tb_mealy_stream_decoder;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sync = 1'b0;
    logic          y_valid = 1'b0;
    logic          y_in = 1'b0;
    logic          y_ready;
    logic          word_valid;
    logic [W-1:0]  word_out;
    logic          word_ready = 1'b1;
    logic [1:0]    tracker_state;
    logic [CW-1:0] bit_count;
`ifdef MEALY_DEC_STATS_EN
    logic [15:0]   word_total;
`endif

    mealy_stream_decoder #(.W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .sync          (sync),
        .y_valid       (y_valid),
        .y_in          (y_in),
        .y_ready       (y_ready),
        .word_valid    (word_valid),
        .word_out      (word_out),
        .word_ready    (word_ready),
        .tracker_state (tracker_state),
        .bit_count     (bit_count)
`ifdef MEALY_DEC_STATS_EN
        ,
        .word_total    (word_total)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_total = 0;
    logic [W-1:0] sb_q[$];
    logic [1:0]   m_state;   // encoder model state: A=0 B=1 C=2

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output side of the scoreboard: a transfer happens on the next edge.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
            end else begin
                logic [W-1:0] e;
                e = sb_q.pop_front();
                chk("word_out", 32'(word_out), 32'(e));
                $display("word transfer: got %02h expected %02h", word_out, e);
            end
        end
    end

    // Offer one Y bit; returns #1 after the edge on which it was accepted.
    task automatic send_bit(input logic y);
        int n;
        n = 0;
        y_valid = 1'b1;
        y_in    = y;
        @(negedge clk);
        while (!y_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!y_ready) chk("y_ready_timeout", 32'(y_ready), 32'd1);
        @(posedge clk);
        #1;
        y_valid = 1'b0;
    endtask

    // Encoder model: turn x bits into the Y stream, then send it.
    task automatic send_word(input logic [W-1:0] xw, input bit gap, input logic [W-1:0] exp_word);
        for (int i = 0; i < W; i++) begin
            logic x;
            logic y;
            x = xw[i];
            y = (m_state == 2'd2) ? x : ~x;
            case (m_state)
                2'd0:    m_state = x ? 2'd1 : 2'd0;
                2'd1:    m_state = x ? 2'd2 : 2'd0;
                default: m_state = x ? 2'd0 : 2'd1;
            endcase
            if (i == W-1) begin
                sb_q.push_back(exp_word);
                exp_total++;
            end
            send_bit(y);
            if (gap) begin
                @(posedge clk);
                #1;
                chk("idle_hold_state", 32'(tracker_state), 32'(m_state));
            end
        end
    endtask

    task automatic do_sync();
        sync = 1'b1;
        @(negedge clk);
        chk("y_ready_during_sync", 32'(y_ready), 32'd0);
        @(posedge clk);
        #1;
        sync = 1'b0;
        m_state = 2'd1;
    endtask

    typedef struct {
        logic [W-1:0] x;
        bit           gap;
        bit           do_sync;
        logic [W-1:0] exp_word;
        logic [1:0]   exp_state;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] t1_stream;

    initial begin
        tbl[0] = '{x: 8'h3C, gap: 1'b0, do_sync: 1'b0, exp_word: 8'h3C, exp_state: 2'd0};
        tbl[1] = '{x: 8'hA7, gap: 1'b1, do_sync: 1'b1, exp_word: 8'hA7, exp_state: 2'd1};
        tbl[2] = '{x: 8'h00, gap: 1'b0, do_sync: 1'b1, exp_word: 8'h00, exp_state: 2'd0};
        tbl[3] = '{x: 8'hFF, gap: 1'b0, do_sync: 1'b1, exp_word: 8'hFF, exp_state: 2'd0};
        tbl[4] = '{x: 8'h55, gap: 1'b0, do_sync: 1'b1, exp_word: 8'h55, exp_state: 2'd1};
        tbl[5] = '{x: 8'hA7, gap: 1'b0, do_sync: 1'b0, exp_word: 8'hA7, exp_state: 2'd1};

        m_state = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_tracker", 32'(tracker_state), 32'd1);
        chk("reset_bit_count", 32'(bit_count), 32'd0);
        chk("reset_word_valid", 32'(word_valid), 32'd0);
        chk("reset_word_out", 32'(word_out), 32'd0);
        chk("reset_y_ready", 32'(y_ready), 32'd1);
`ifdef MEALY_DEC_STATS_EN
        chk("reset_word_total", 32'(word_total), 32'd0);
`endif

        // Raw Y stream 0,1,0,1,1,0,1,0 decodes to 0xA7 and ends in B.
        t1_stream = 8'b0101_1010;   // bit 7 is sent first
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                sb_q.push_back(8'hA7);
                exp_total++;
                chk("t1_valid_before_last", 32'(word_valid), 32'd0);
            end
            send_bit(t1_stream[7-i]);
        end
        chk("t1_valid_latency", 32'(word_valid), 32'd1);
        chk("t1_word", 32'(word_out), 32'hA7);
        chk("t1_tracker", 32'(tracker_state), 32'd1);
        chk("t1_bit_count", 32'(bit_count), 32'd0);
        m_state = 2'd1;
        @(posedge clk);
        #1;

        // Held output: seven partial bits pass, the eighth stalls.
        word_ready = 1'b0;
        send_word(8'hA7, 1'b0, 8'hA7);
        chk("t2_valid", 32'(word_valid), 32'd1);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("t2_count7", 32'(bit_count), 32'd7);
        chk("t2_word_held", 32'(word_out), 32'hA7);
        sb_q.push_back(8'h00);
        exp_total++;
        y_valid = 1'b1;
        y_in    = 1'b1;
        @(negedge clk);
        chk("t2_stall", 32'(y_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_stall_word", 32'(word_out), 32'hA7);
        chk("t2_stall_valid", 32'(word_valid), 32'd1);
        chk("t2_stall_count", 32'(bit_count), 32'd7);
        word_ready = 1'b1;
        @(negedge clk);
        chk("t2_unstall", 32'(y_ready), 32'd1);
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        chk("t2_load_on_drain_valid", 32'(word_valid), 32'd1);
        chk("t2_load_on_drain_word", 32'(word_out), 32'h00);
        chk("t2_tracker", 32'(tracker_state), 32'd0);
        m_state = 2'd0;
        @(posedge clk);
        #1;

        // Sync discards a partial word and re-aligns the tracker.
        do_sync();
        chk("t3_sync_tracker", 32'(tracker_state), 32'd1);
        send_bit(1'b0);
        chk("t3_tracker_c", 32'(tracker_state), 32'd2);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t3_count3", 32'(bit_count), 32'd3);
        chk("t3_tracker_b", 32'(tracker_state), 32'd1);
        do_sync();
        chk("t3_count_cleared", 32'(bit_count), 32'd0);
        chk("t3_tracker_realign", 32'(tracker_state), 32'd1);
        chk("t3_valid_untouched", 32'(word_valid), 32'd0);

        // Table of words (first entry decodes as the fresh word after sync).
        for (int k = 0; k < 6; k++) begin
            int c0;
            if (tbl[k].do_sync) do_sync();
            c0 = cyc;
            send_word(tbl[k].x, tbl[k].gap, tbl[k].exp_word);
            if (!tbl[k].gap) chk("zero_bubble_cycles", 32'(cyc - c0), 32'd8);
            chk("table_tracker", 32'(tracker_state), 32'(tbl[k].exp_state));
            chk("table_bit_count", 32'(bit_count), 32'd0);
            $display("vector %0d: x=%02h gap=%0d tracker=%0d", k, tbl[k].x, tbl[k].gap, tracker_state);
        end
        @(posedge clk);
        #1;

        // Reset mid-word with a held word drops everything.
        do_sync();
        word_ready = 1'b0;
        send_word(8'h5A, 1'b0, 8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        chk("t5_count5", 32'(bit_count), 32'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_total = 0;
        m_state = 2'd1;
        chk("t5_valid", 32'(word_valid), 32'd0);
        chk("t5_count", 32'(bit_count), 32'd0);
        chk("t5_tracker", 32'(tracker_state), 32'd1);
        chk("t5_word_out", 32'(word_out), 32'd0);
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Three words then sync; the statistics counter survives sync.
        send_word(8'h12, 1'b0, 8'h12);
        send_word(8'hC3, 1'b0, 8'hC3);
        send_word(8'h7E, 1'b0, 8'h7E);
`ifdef MEALY_DEC_STATS_EN
        chk("t6_total_before_sync", 32'(word_total), 32'(exp_total));
`endif
        do_sync();
`ifdef MEALY_DEC_STATS_EN
        chk("t6_total_after_sync", 32'(word_total), 32'd3);
`endif

        begin
            int n;
            n = 0;
            while (sb_q.size() != 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
            #1;
            chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
